// File: rtl/booth_pkg.sv
// Shared defaults, state encoding and counter sizing for the sequential signed divider.
package booth_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // The step counter must be able to hold the value DW itself.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift in a dividend bit,
// trial-subtract the divisor magnitude and keep the difference only if it fits.
module div_step #(
  parameter int VW = booth_pkg::VW_DEF
) (
  input  logic [VW:0] rem_in,
  input  logic        bit_in,
  input  logic [VW:0] dvs_mag,
  output logic [VW:0] rem_out,
  output logic        q_bit
);

  localparam int RW = VW + 1;

  logic [RW:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, dvs_mag});
    rem_out = q_bit ? RW'(shifted - {1'b0, dvs_mag}) : RW'(shifted);
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: DW restoring steps on magnitudes, then a sign-fix
// cycle; fixed latency regardless of operand values.
module seq_signed_divider
  import booth_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);

  localparam int CW = cnt_width(DW);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // |most negative dividend| is exact as a DW-bit unsigned value.
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW:0]   dvs_q, dvs_d;
  logic [VW:0]   rem_q, rem_d;
  logic          neg_a_q, neg_a_d;
  logic          neg_b_q, neg_b_d;
  logic          zero_b_q, zero_b_d;
  logic [VW-1:0] a_low_q, a_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [VW:0]   step_rem;
  logic          step_q_bit;

  div_step #(.VW(VW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DW-1]),
    .dvs_mag (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    zero_b_d = zero_b_q;
    a_low_d  = a_low_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          neg_a_d  = dividend[DW-1];
          neg_b_d  = divisor[VW-1];
          zero_b_d = (divisor == '0);
          a_low_d  = dividend[VW-1:0];
          dvd_d    = dividend[DW-1] ? -dividend : dividend;
          dvs_d    = divisor[VW-1] ? -{1'b1, divisor} : {1'b0, divisor};
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == CW'(DW)) begin
          state_d = FIX;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[DW-2:0], step_q_bit};
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        if (zero_b_q) begin
          quot_d = '1;
          remo_d = a_low_q;
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
          remo_d = neg_a_q ? -rem_q[VW-1:0] : rem_q[VW-1:0];
          dz_d   = 1'b0;
          // A positive quotient with its top bit set cannot be represented.
          ovf_d  = ~(neg_a_q ^ neg_b_q) & dvd_q[DW-1];
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      zero_b_q <= 1'b0;
      a_low_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      remo_q   <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      zero_b_q <= zero_b_d;
      a_low_q  <= a_low_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench: the driver pushes reference results computed with integer
// arithmetic; a monitor pops and compares on every done pulse.
module tb_seq_signed_divider;

  localparam int DW  = 8;
  localparam int VW  = 4;
  localparam int LAT = 10;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic          ov;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_zero, ovf;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  seq_signed_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: truncating integer division, with the two flagged corner cases.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input int acc);
    exp_t e;
    int   sa;
    int   sv;
    sa    = int'($signed(a));
    sv    = int'($signed(b));
    e.acc = acc;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (sv == 0) begin
      e.dz = 1'b1;
      e.q  = '1;
      e.r  = a[VW-1:0];
    end else if (sa == -(2 ** (DW - 1)) && sv == -1) begin
      e.ov = 1'b1;
      e.q  = a;
      e.r  = '0;
    end else begin
      e.q = DW'(sa / sv);
      e.r = VW'(sa % sv);
    end
    return e;
  endfunction

  // Waits for a cycle where start is accepted, then records the expected result.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int guard;
    guard = 0;
    if (clk) @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("issue_timeout", 32'(guard >= 40), 32'd0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(a, b, cyc));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_quot"}, 32'(quotient), 32'd0);
    check({tag, "_rem"}, 32'(remainder), 32'd0);
    check({tag, "_dz"}, 32'(div_zero), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      check("done_single", 32'(prev_done), 32'd0);
      check("busy_at_done", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("ovf", 32'(ovf), 32'(e.ov));
        check("latency", 32'(cyc - e.acc), 32'(LAT));
      end
    end
    prev_done = done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    #1 rst_n = 1'b0;
    #3 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release, with a second start ignored during CALC.
    issue(8'd100, 4'd7);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd1;
    divisor  = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_in_calc", 32'(busy), 32'd1);

    // Issued in the DONE cycle of the previous division: back-to-back.
    issue(-8'sd100, 4'd7);
    issue(8'd100, -4'sd7);
    issue(8'h80, 4'hF);
    issue(8'h80, 4'd2);
    issue(8'd50, 4'd0);
    issue(8'd100, -4'sd7);
    drain();

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold_quot", 32'(quotient), 32'(8'hF2));
    check("hold_rem", 32'(remainder), 32'(4'd2));
    check("hold_busy", 32'(busy), 32'd0);

    // Reset in the middle of a division.
    issue(8'd100, 4'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);
    issue(8'd100, 4'd7);
    drain();

    // Random operands, mostly back-to-back, with the corner values weighted in.
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      issue(ra, rb);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
